// File: rtl/accum_capture_multi.sv
// Run-length accumulator: steps an index 0..cnt_limit, adds it into acc each
// RUN cycle, and latches acc into each port whose capture index is reached.
module accum_capture_multi #(
    parameter int WIDTH    = 8,
    parameter int CNT_W    = 8,
    parameter int NPORTS   = 2,
    parameter int SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [CNT_W-1:0]          cnt_limit,
    input  logic [NPORTS*CNT_W-1:0]   cap_idx,
    input  logic [NPORTS-1:0]         cap_en,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          count,
    output logic [WIDTH-1:0]          acc,
    output logic                      ovf,
    output logic [NPORTS-1:0]         load,
    output logic [NPORTS*WIDTH-1:0]   port_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [WIDTH-1:0]          acc_q, acc_d;
    logic                      ovf_q, ovf_d;
    logic [NPORTS-1:0]         load_q, load_d;
    logic [NPORTS*WIDTH-1:0]   port_d;

    logic [WIDTH-1:0]          c_ext;
    logic [WIDTH:0]            sum;
    logic [WIDTH-1:0]          acc_new;

    // The index is brought to the accumulator width before the add.
    if (CNT_W >= WIDTH) begin : g_trunc
        assign c_ext = count_q[WIDTH-1:0];
    end else begin : g_ext
        assign c_ext = {{(WIDTH-CNT_W){1'b0}}, count_q};
    end

    assign sum = {1'b0, acc_q} + {1'b0, c_ext};

    always_comb begin
        acc_new = sum[WIDTH-1:0];
        if (SATURATE != 0 && sum[WIDTH]) begin
            acc_new = '1;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        load_d  = '0;
        port_d  = port_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    count_d = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_new;
                    ovf_d = ovf_q | sum[WIDTH];
                    if (count_q == cnt_limit) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                    // Captured value is the post-add accumulator.
                    for (int i = 0; i < NPORTS; i++) begin
                        if (cap_en[i] && cap_idx[i*CNT_W +: CNT_W] == count_q) begin
                            port_d[i*WIDTH +: WIDTH] = acc_new;
                            load_d[i]                = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            load_q  <= '0;
            port_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            load_q  <= load_d;
            port_q  <= port_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign count = count_q;
    assign acc   = acc_q;
    assign ovf   = ovf_q;
    assign load  = load_q;

endmodule

// File: tb/tb_accum_capture_multi.sv
// Bench for accum_capture_multi: wrapping and saturating instances share stimulus
// and are compared every cycle against a run-total model.
module tb_accum_capture_multi;

    localparam int W  = 8;
    localparam int CW = 8;
    localparam int NP = 2;

    logic              clk = 1'b0;
    logic              rst, start, abort;
    logic [CW-1:0]     cnt_limit;
    logic [NP*CW-1:0]  cap_idx;
    logic [NP-1:0]     cap_en;

    logic              busy, done, ovf;
    logic [CW-1:0]     count;
    logic [W-1:0]      acc;
    logic [NP-1:0]     load;
    logic [NP*W-1:0]   port_q;

    logic              s_busy, s_done, s_ovf;
    logic [CW-1:0]     s_count;
    logic [W-1:0]      s_acc;
    logic [NP-1:0]     s_load;
    logic [NP*W-1:0]   s_port_q;

    accum_capture_multi #(.WIDTH(W), .CNT_W(CW), .NPORTS(NP), .SATURATE(0)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cnt_limit(cnt_limit),
        .cap_idx(cap_idx), .cap_en(cap_en), .busy(busy), .done(done), .count(count),
        .acc(acc), .ovf(ovf), .load(load), .port_q(port_q)
    );

    accum_capture_multi #(.WIDTH(W), .CNT_W(CW), .NPORTS(NP), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cnt_limit(cnt_limit),
        .cap_idx(cap_idx), .cap_en(cap_en), .busy(s_busy), .done(s_done), .count(s_count),
        .acc(s_acc), .ovf(s_ovf), .load(s_load), .port_q(s_port_q)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: phase 0=idle 1=run 2=done; the true (unbounded) run total is kept,
    // and the wrapped / clamped views are derived from it.
    int          m_phase = 0;
    int          m_count = 0;
    int          m_total = 0;
    int          m_port_total[NP];
    logic [NP-1:0] m_load = '0;

    int busy_cycles = 0;
    int done_cycles = 0;

    function automatic int wrap_of(input int t);
        return t % 256;
    endfunction

    function automatic int sat_of(input int t);
        return (t > 255) ? 255 : t;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_phase = 0; m_count = 0; m_total = 0; m_load = '0;
            for (int i = 0; i < NP; i++) m_port_total[i] = 0;
        end else begin
            m_load = '0;
            case (m_phase)
                0: if (start) begin
                       m_phase = 1; m_count = 0; m_total = 0;
                   end
                1: if (abort) begin
                       m_phase = 0;
                   end else begin
                       m_total += m_count;
                       for (int i = 0; i < NP; i++) begin
                           if (cap_en[i] && int'(cap_idx[i*CW +: CW]) == m_count) begin
                               m_port_total[i] = m_total;
                               m_load[i] = 1'b1;
                           end
                       end
                       if (m_count == int'(cnt_limit)) m_phase = 2;
                       else m_count++;
                   end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic checkOutput();
        check("busy",     busy,     m_phase == 1);
        check("done",     done,     m_phase == 2);
        check("count",    count,    m_count);
        check("acc",      acc,      wrap_of(m_total));
        check("ovf",      ovf,      m_total > 255);
        check("load",     load,     m_load);
        check("s_busy",   s_busy,   m_phase == 1);
        check("s_done",   s_done,   m_phase == 2);
        check("s_count",  s_count,  m_count);
        check("s_acc",    s_acc,    sat_of(m_total));
        check("s_ovf",    s_ovf,    m_total > 255);
        check("s_load",   s_load,   m_load);
        for (int i = 0; i < NP; i++) begin
            check($sformatf("port%0d", i),   port_q[i*W +: W],   wrap_of(m_port_total[i]));
            check($sformatf("s_port%0d", i), s_port_q[i*W +: W], sat_of(m_port_total[i]));
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        model_step();
        #1;
        if (busy) busy_cycles++;
        if (done) done_cycles++;
        checkOutput();
    endtask

    task automatic launch(input int lim);
        cnt_limit = CW'(lim);
        start = 1'b1;
        busy_cycles = 0;
        done_cycles = 0;
        applyStimulus();
        start = 1'b0;
    endtask

    task automatic run_until_idle(input int bound);
        int n = 0;
        while (m_phase != 0 && n < bound) begin
            applyStimulus();
            n++;
        end
        if (m_phase != 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL timeout observed=busy expected=idle");
        end
    endtask

    task automatic wait_count(input int target);
        int n = 0;
        while (m_count != target && n < 300) begin
            applyStimulus();
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cnt_limit = '0; cap_idx = '0; cap_en = '0;
        applyStimulus();
        applyStimulus();
        check("rst_acc", acc, 0);
        check("rst_port", port_q, 0);
        rst = 1'b0;
        applyStimulus();

        // Two captures at 10 and 20, no overflow.
        cap_idx = {8'd20, 8'd10};
        cap_en  = 2'b11;
        launch(20);
        run_until_idle(60);
        check("t1_busy_len", busy_cycles, 21);
        check("t1_done_len", done_cycles, 1);
        check("t1_port0", port_q[7:0], 55);
        check("t1_port1", port_q[15:8], 210);
        check("t1_ovf", ovf, 0);

        // Overflow: wrap vs clamp.
        cap_en = 2'b00;
        launch(30);
        run_until_idle(60);
        check("t2_acc", acc, 209);
        check("t2_ovf", ovf, 1);
        check("t2_s_acc", s_acc, 255);
        check("t2_s_ovf", s_ovf, 1);
        check("t2_port1_hold", port_q[15:8], 210);

        // Capture at index 0, second port beyond the limit never captures.
        cap_idx = {8'd9, 8'd0};
        cap_en  = 2'b11;
        launch(5);
        run_until_idle(30);
        check("t3_busy_len", busy_cycles, 6);
        check("t3_port0", port_q[7:0], 0);
        check("t3_port1", port_q[15:8], 210);

        // Abort at count 5; start and abort together in idle, start wins.
        cap_en = 2'b00;
        abort  = 1'b1;
        launch(20);
        abort  = 1'b0;
        wait_count(5);
        abort = 1'b1;
        applyStimulus();
        abort = 1'b0;
        check("t4_acc", acc, 10);
        check("t4_count", count, 5);
        check("t4_busy", busy, 0);
        applyStimulus();
        check("t4_no_done", done, 0);

        // Abort after overflow, then restart clears ovf.
        launch(30);
        wait_count(25);
        abort = 1'b1;
        applyStimulus();
        abort = 1'b0;
        check("t4b_ovf", ovf, 1);
        launch(3);
        check("t4b_ovf_clr", ovf, 0);
        check("t4b_acc_clr", acc, 0);
        run_until_idle(20);

        // Reset mid-run.
        cap_idx = {8'd3, 8'd7};
        cap_en  = 2'b11;
        launch(20);
        wait_count(12);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_count", count, 0);
        check("t5_acc", acc, 0);
        check("t5_port", port_q, 0);
        applyStimulus();
        check("t5_no_done", done, 0);

        // start pulses inside the run do not change its length.
        launch(20);
        for (int k = 0; k < 60 && m_phase != 0; k++) begin
            start = (k % 3 == 0);
            applyStimulus();
        end
        start = 1'b0;
        check("t5_busy_len", busy_cycles, 21);

        // Single-cycle run with both ports at index 0.
        cap_idx = {8'd0, 8'd0};
        cap_en  = 2'b11;
        launch(0);
        run_until_idle(10);
        check("lim0_busy_len", busy_cycles, 1);

        // Full-range index with no count wrap.
        cap_idx = {8'd255, 8'd128};
        launch(255);
        run_until_idle(300);
        check("lim255_busy_len", busy_cycles, 256);
        check("lim255_count", count, 255);

        // Randomised runs with stray start/abort.
        for (int r = 0; r < 25; r++) begin
            int lim;
            lim = $urandom_range(0, 40);
            for (int i = 0; i < NP; i++) begin
                int ci;
                ci = $urandom_range(0, lim + 3);
                cap_idx[i*CW +: CW] = CW'(ci);
            end
            cap_en = NP'($urandom_range(0, 3));
            launch(lim);
            for (int k = 0; k < 300 && m_phase != 0; k++) begin
                start = ($urandom_range(0, 3) == 0);
                abort = ($urandom_range(0, 40) == 0);
                applyStimulus();
            end
            start = 1'b0;
            abort = 1'b0;
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
